// File: rtl/xbar_slave_arbiter.sv
// Purpose: round-robin arbiter sharing one crossbar slave port among NUM_MASTERS masters.
// Latency: one idle (arbitration) cycle before s_req; ack and resp are routed back combinationally.
// Backpressure: the granted master waits on s_ack; a read holds the grant until s_resp or timeout.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m_req/m_addr/m_cmd/m_wdata packed per-master request bundle (master i at slice i)
//   m_ack, m_resp, m_rdata    per-master accept/read-response strobes, shared read data
//   s_req/s_addr/s_cmd/s_wdata request forwarded to the slave
//   s_ack, s_resp, s_rdata    slave accept/read-response strobes and read data
//   timeout                   one-cycle pulse when an outstanding read is abandoned
module xbar_slave_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]            m_cmd,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_resp,
  output logic                              s_req,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic                              s_cmd,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic                              s_ack,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_resp,
  output logic                              timeout
);

  localparam int GW = $clog2(NUM_MASTERS);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  state_e        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic [GW-1:0] grant_d;
  logic          grant_found;
  logic [CW-1:0] cnt_q;
  logic          tmo_hit;

  // Unpack the flat per-master buses so the grant index selects a whole word.
  logic [ADDR_WIDTH-1:0] addr_a  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_a[g]  = m_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = m_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first requester strictly after last_q, wrapping.
  always_comb begin
    int            idx;
    logic [GW-1:0] sel;
    grant_d     = last_q;
    grant_found = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = (int'(last_q) + i) % NUM_MASTERS;
      sel = GW'(idx);
      if (!grant_found && m_req[sel]) begin
        grant_d     = sel;
        grant_found = 1'b1;
      end
    end
  end

  // Abandon the read on the last allowed wait cycle; a same-cycle s_resp wins.
  assign tmo_hit = (TIMEOUT != 0) && (state_q == WAIT_RESP) && !s_resp &&
                   (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    s_req   = 1'b0;
    s_addr  = '0;
    s_cmd   = 1'b0;
    s_wdata = '0;
    m_ack   = '0;
    m_resp  = '0;
    m_rdata = '0;
    timeout = 1'b0;
    case (state_q)
      BUSY: begin
        s_req          = m_req[grant_q];
        s_addr         = addr_a[grant_q];
        s_cmd          = m_cmd[grant_q];
        s_wdata        = wdata_a[grant_q];
        m_ack[grant_q] = s_ack;
      end
      WAIT_RESP: begin
        m_rdata         = s_rdata;
        m_resp[grant_q] = s_resp;
        if (tmo_hit) begin
          // Complete the read towards the master with zero data.
          m_resp[grant_q] = 1'b1;
          m_rdata         = '0;
          timeout         = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            grant_q <= grant_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!m_req[grant_q]) begin
            // Master withdrew before ack: abandon without advancing priority.
            state_q <= IDLE;
          end else if (s_ack) begin
            if (m_cmd[grant_q]) begin
              state_q <= IDLE;
              last_q  <= grant_q;
            end else begin
              state_q <= WAIT_RESP;
              cnt_q   <= '0;
            end
          end
        end
        WAIT_RESP: begin
          if (s_resp || tmo_hit) begin
            state_q <= IDLE;
            last_q  <= grant_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_slave_arbiter.sv
module tb_xbar_slave_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req;
  logic [NM*AW-1:0]  m_addr;
  logic [NM-1:0]     m_cmd;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM-1:0]     m_ack;
  logic [DW-1:0]     m_rdata;
  logic [NM-1:0]     m_resp;
  logic              s_req;
  logic [AW-1:0]     s_addr;
  logic              s_cmd;
  logic [DW-1:0]     s_wdata;
  logic              s_ack;
  logic [DW-1:0]     s_rdata;
  logic              s_resp;
  logic              timeout;

  logic [AW-1:0] ma [NM];
  logic [DW-1:0] mw [NM];

  assign m_addr  = {ma[3], ma[2], ma[1], ma[0]};
  assign m_wdata = {mw[3], mw[2], mw[1], mw[0]};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xbar_slave_arbiter #(
    .NUM_MASTERS(NM),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_addr (m_addr),
    .m_cmd  (m_cmd),
    .m_wdata(m_wdata),
    .m_ack  (m_ack),
    .m_rdata(m_rdata),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_addr (s_addr),
    .s_cmd  (s_cmd),
    .s_wdata(s_wdata),
    .s_ack  (s_ack),
    .s_rdata(s_rdata),
    .s_resp (s_resp),
    .timeout(timeout)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic req, input logic cmd,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_req[i[1:0]] = req;
    m_cmd[i[1:0]] = cmd;
    ma[i[1:0]]    = a;
    mw[i[1:0]]    = d;
  endtask

  task automatic test_reset;
    rst = 1'b1; m_req = '0; m_cmd = '0; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    for (int i = 0; i < NM; i++) begin ma[i] = $urandom; mw[i] = $urandom; end
    step; step;
    m_req = 4'hF; m_cmd = 4'hF; s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({s_req, m_ack, m_resp, timeout, s_cmd} !== 11'd0) begin
      errors++; $display("FAIL rst_strobes got %b exp 0", {s_req, m_ack, m_resp, timeout, s_cmd});
    end
    checks++;
    if ({s_addr, s_wdata, m_rdata} !== 96'd0) begin
      errors++; $display("FAIL rst_data got %h exp 0", {s_addr, s_wdata, m_rdata});
    end
    step;
    rst = 1'b0; m_req = '0; m_cmd = '0; s_ack = 1'b0; s_resp = 1'b0;
    #1;
    checks++;
    if ({s_req, m_ack, m_resp, timeout} !== 10'd0) begin
      errors++; $display("FAIL rst_idle got %b exp 0", {s_req, m_ack, m_resp, timeout});
    end
  endtask

  task automatic test_single_write;
    step; set_m(2, 1'b1, 1'b1, 32'h1000_0040, 32'hA5A5_A5A5); #1;
    checks++;
    if (s_req !== 1'b0) begin errors++; $display("FAIL wr_idle_sreq got %b exp 0", s_req); end
    step; #1;
    checks++;
    if (s_req !== 1'b1) begin errors++; $display("FAIL wr_sreq got %b exp 1", s_req); end
    checks++;
    if (s_addr !== 32'h1000_0040) begin errors++; $display("FAIL wr_addr got %h exp 10000040", s_addr); end
    checks++;
    if (s_wdata !== 32'hA5A5_A5A5 || s_cmd !== 1'b1) begin
      errors++; $display("FAIL wr_data got %h/%b exp a5a5a5a5/1", s_wdata, s_cmd);
    end
    step; #1;
    checks++;
    if (s_req !== 1'b1 || m_ack !== 4'b0000) begin
      errors++; $display("FAIL wr_hold got %b/%b exp 1/0000", s_req, m_ack);
    end
    step; s_ack = 1'b1; #1;
    checks++;
    if (m_ack !== 4'b0100 || m_resp !== 4'b0000) begin
      errors++; $display("FAIL wr_ack got %b/%b exp 0100/0000", m_ack, m_resp);
    end
    step; s_ack = 1'b0; m_req[2] = 1'b0; #1;
    checks++;
    if (s_req !== 1'b0 || m_ack !== 4'b0000 || s_addr !== 32'd0 || m_resp !== 4'b0000) begin
      errors++; $display("FAIL wr_done got %b/%b/%h exp idle", s_req, m_ack, s_addr);
    end
  endtask

  task automatic test_single_read;
    step; set_m(1, 1'b1, 1'b0, $urandom, '0); #1;
    step; s_ack = 1'b1; #1;
    checks++;
    if (s_req !== 1'b1 || s_cmd !== 1'b0 || m_ack !== 4'b0010 || s_addr !== ma[1]) begin
      errors++; $display("FAIL rd_ack got %b/%b/%b/%h exp 1/0/0010/%h", s_req, s_cmd, m_ack, s_addr, ma[1]);
    end
    for (int w = 0; w < 2; w++) begin
      step; s_ack = 1'b0; m_req[1] = 1'b0; s_rdata = $urandom; #1;
      checks++;
      if (s_req !== 1'b0 || m_resp !== 4'b0000 || m_ack !== 4'b0000) begin
        errors++; $display("FAIL rd_wait got %b/%b/%b exp 0/0000/0000", s_req, m_resp, m_ack);
      end
    end
    step; s_resp = 1'b1; s_rdata = 32'h1234_5678; #1;
    checks++;
    if (m_resp !== 4'b0010) begin errors++; $display("FAIL rd_resp got %b exp 0010", m_resp); end
    checks++;
    if (m_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data got %h exp 12345678", m_rdata); end
    step; s_resp = 1'b0; #1;
    checks++;
    if (m_resp !== 4'b0000 || m_rdata !== 32'd0) begin
      errors++; $display("FAIL rd_done got %b/%h exp 0000/0", m_resp, m_rdata);
    end
  endtask

  task automatic test_round_robin;
    int m;
    step; rst = 1'b1;
    step; rst = 1'b0;
    for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 32'h2000_0000 + i * 16, $urandom);
    s_ack = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step;
      #1;
      if (k % 2 == 0) begin
        checks++;
        if (s_req !== 1'b0 || m_ack !== 4'b0000) begin
          errors++; $display("FAIL rr_gap%0d got %b/%b exp 0/0000", k, s_req, m_ack);
        end
      end else begin
        m = (k / 2) % NM;
        checks++;
        if (m_ack !== 4'(1 << m) || s_addr !== ma[m]) begin
          errors++; $display("FAIL rr_grant%0d got %b/%h exp %b/%h", k, m_ack, s_addr, 4'(1 << m), ma[m]);
        end
      end
    end
    step; m_req = '0; m_cmd = '0; s_ack = 1'b0;
  endtask

  task automatic test_read_blocking;
    logic [DW-1:0] r;
    step; set_m(0, 1'b1, 1'b0, $urandom, '0); #1;
    step; s_ack = 1'b1; set_m(3, 1'b1, 1'b1, $urandom, $urandom); #1;
    checks++;
    if (m_ack !== 4'b0001) begin errors++; $display("FAIL blk_ack0 got %b exp 0001", m_ack); end
    for (int w = 0; w < 4; w++) begin
      step; s_ack = 1'b0; m_req[0] = 1'b0; #1;
      checks++;
      if (s_req !== 1'b0 || m_ack !== 4'b0000) begin
        errors++; $display("FAIL blk_hold%0d got %b/%b exp 0/0000", w, s_req, m_ack);
      end
    end
    r = $urandom;
    step; s_resp = 1'b1; s_rdata = r; #1;
    checks++;
    if (m_resp !== 4'b0001 || m_rdata !== r) begin
      errors++; $display("FAIL blk_resp got %b/%h exp 0001/%h", m_resp, m_rdata, r);
    end
    step; s_resp = 1'b0; #1;
    checks++;
    if (s_req !== 1'b0) begin errors++; $display("FAIL blk_idle got %b exp 0", s_req); end
    step; s_ack = 1'b1; #1;
    checks++;
    if (s_req !== 1'b1 || m_ack !== 4'b1000 || s_addr !== ma[3]) begin
      errors++; $display("FAIL blk_next got %b/%b/%h exp 1/1000/%h", s_req, m_ack, s_addr, ma[3]);
    end
    step; s_ack = 1'b0; m_req[3] = 1'b0; #1;
  endtask

  task automatic test_timeout;
    step; set_m(2, 1'b1, 1'b0, $urandom, '0); #1;
    step; s_ack = 1'b1; #1;
    checks++;
    if (m_ack !== 4'b0100) begin errors++; $display("FAIL to_ack got %b exp 0100", m_ack); end
    for (int w = 1; w < TO; w++) begin
      step; s_ack = 1'b0; m_req[2] = 1'b0; s_rdata = 32'hDEAD_BEEF; #1;
      checks++;
      if (m_resp !== 4'b0000 || timeout !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d got %b/%b exp 0000/0", w, m_resp, timeout);
      end
    end
    step; #1;
    checks++;
    if (m_resp !== 4'b0100 || m_rdata !== 32'd0 || timeout !== 1'b1) begin
      errors++; $display("FAIL to_fire got %b/%h/%b exp 0100/0/1", m_resp, m_rdata, timeout);
    end
    step; s_resp = 1'b1; #1;
    checks++;
    if (m_resp !== 4'b0000 || m_rdata !== 32'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL to_late got %b/%h/%b exp 0000/0/0", m_resp, m_rdata, timeout);
    end
    step; s_resp = 1'b0; #1;
    checks++;
    if (s_req !== 1'b0 || m_resp !== 4'b0000) begin
      errors++; $display("FAIL to_after got %b/%b exp 0/0000", s_req, m_resp);
    end
  endtask

  task automatic test_reset_mid_read;
    step; set_m(1, 1'b1, 1'b0, $urandom, '0); #1;
    step; s_ack = 1'b1; #1;
    step; s_ack = 1'b0; m_req[1] = 1'b0; #1;
    step; rst = 1'b1; #1;
    step; rst = 1'b0; s_resp = 1'b1; s_rdata = $urandom;
    for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, $urandom, $urandom);
    #1;
    checks++;
    if ({s_req, m_ack, m_resp, timeout, s_cmd} !== 11'd0 || {s_addr, s_wdata, m_rdata} !== 96'd0) begin
      errors++; $display("FAIL rstmid_out got %b/%h exp 0/0", {s_req, m_ack, m_resp, timeout},
                         {s_addr, s_wdata, m_rdata});
    end
    step; s_resp = 1'b0; s_ack = 1'b1; #1;
    checks++;
    if (m_ack !== 4'b0001 || s_addr !== ma[0]) begin
      errors++; $display("FAIL rstmid_first got %b/%h exp 0001/%h", m_ack, s_addr, ma[0]);
    end
    step; s_ack = 1'b0; m_req = '0; m_cmd = '0; #1;
  endtask

  // Transaction-level reference: phase 0 = slave port free (arbitration cycle),
  // 1 = request presented to slave, 2 = read outstanding.
  task automatic test_random;
    int phase, cur, last, dly, cand;
    logic [NM-1:0] acked;
    step; rst = 1'b1; m_req = '0; m_cmd = '0; s_ack = 1'b0; s_resp = 1'b0;
    step; rst = 1'b0;
    phase = 0; cur = 0; last = NM - 1; dly = 0; acked = '0;
    for (int c = 0; c < 3000; c++) begin
      m_req = m_req & ~acked;
      acked = '0;
      for (int i = 0; i < NM; i++) begin
        if (!m_req[i] && $urandom_range(0, 3) == 0)
          set_m(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      s_ack = 1'b0; s_resp = 1'b0; s_rdata = $urandom;
      if (phase == 1) begin
        if (dly == 0) s_ack = 1'b1; else dly--;
      end else if (phase == 2) begin
        if (dly == 0) s_resp = 1'b1; else dly--;
      end else begin
        s_resp = 1'($urandom_range(0, 7) == 0);
        s_ack  = 1'($urandom_range(0, 7) == 0);
      end
      #1;
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL rnd_tmo c%0d got %b exp 0", c, timeout); end
      if (phase == 0) begin
        checks++;
        if (s_req !== 1'b0 || m_ack !== 4'b0000 || m_resp !== 4'b0000) begin
          errors++; $display("FAIL rnd_free c%0d got %b/%b/%b exp 0/0000/0000", c, s_req, m_ack, m_resp);
        end
      end else if (phase == 1) begin
        checks++;
        if (s_req !== 1'b1 || s_addr !== ma[cur[1:0]] || s_cmd !== m_cmd[cur[1:0]] ||
            s_wdata !== mw[cur[1:0]]) begin
          errors++; $display("FAIL rnd_req c%0d got %b/%h/%b/%h exp 1/%h/%b/%h (m%0d)", c, s_req, s_addr,
                             s_cmd, s_wdata, ma[cur[1:0]], m_cmd[cur[1:0]], mw[cur[1:0]], cur);
        end
        checks++;
        if (m_ack !== (s_ack ? 4'(1 << cur) : 4'b0000) || m_resp !== 4'b0000) begin
          errors++; $display("FAIL rnd_ack c%0d got %b/%b exp m%0d ack=%b", c, m_ack, m_resp, cur, s_ack);
        end
      end else begin
        checks++;
        if (s_req !== 1'b0 || m_ack !== 4'b0000 || m_resp !== (s_resp ? 4'(1 << cur) : 4'b0000)) begin
          errors++; $display("FAIL rnd_resp c%0d got %b/%b/%b exp m%0d resp=%b", c, s_req, m_ack, m_resp,
                             cur, s_resp);
        end
        if (s_resp) begin
          checks++;
          if (m_rdata !== s_rdata) begin
            errors++; $display("FAIL rnd_rdata c%0d got %h exp %h", c, m_rdata, s_rdata);
          end
        end
      end
      if (phase == 0) begin
        if (m_req != '0) begin
          for (int k = 1; k <= NM; k++) begin
            cand = (last + k) % NM;
            if (m_req[cand[1:0]]) begin cur = cand; break; end
          end
          phase = 1;
          dly = $urandom_range(0, 2);
        end
      end else if (phase == 1) begin
        if (s_ack) begin
          acked[cur[1:0]] = 1'b1;
          if (m_cmd[cur[1:0]]) begin
            last = cur; phase = 0;
          end else begin
            phase = 2; dly = $urandom_range(0, 3);
          end
        end
      end else if (s_resp) begin
        last = cur; phase = 0;
      end
      step;
    end
    m_req = '0; s_ack = 1'b0; s_resp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; m_req = '0; m_cmd = '0; s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    for (int i = 0; i < NM; i++) begin ma[i] = '0; mw[i] = '0; end
    test_reset;
    test_single_write;
    test_single_read;
    test_round_robin;
    test_read_blocking;
    test_timeout;
    test_reset_mid_read;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
